// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared register-file definitions for the writeback scheduler and its users.
package regfile_pkg;

    localparam int REG_AW = 5;
    localparam int REG_DW = 32;
    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [REG_DW-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_scheduler_rr_arbiter.sv
// N-wide round-robin arbiter: one-hot grant, pointer moves past the winner.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_nxt;
    logic [N-1:0]  mask;
    logic [N-1:0]  hi;

    // Requests at or above the pointer win; otherwise wrap to the lowest.
    always_comb begin
        mask    = '0;
        grant   = '0;
        ptr_nxt = ptr;
        for (int i = 0; i < N; i++)
            mask[i] = (i >= int'(ptr));
        hi = req & mask;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
                ptr_nxt  = PW'((i + 1) % N);
            end
        end
        if (|hi) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (hi[i]) begin
                    grant    = '0;
                    grant[i] = 1'b1;
                    ptr_nxt  = PW'((i + 1) % N);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            ptr <= '0;
        else
            ptr <= ptr_nxt;
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Round-robin writeback port sharing with a per-register busy scoreboard.
// Optional WB_FORWARD_EN adds commit-cycle forwarding of source operands.
module regfile_wb_scheduler
    import regfile_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int AW   = REG_AW,
    parameter int DW   = REG_DW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue_valid,
    input  logic [AW-1:0]    issue_rd,
    output logic             issue_ready,
    input  logic [NREQ-1:0]  req_valid,
    input  logic [NREQ*AW-1:0] req_rd,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]  req_ready,
    input  logic [AW-1:0]    rs1,
    input  logic [AW-1:0]    rs2,
    output logic             rs1_busy,
    output logic             rs2_busy,
`ifdef WB_FORWARD_EN
    output logic             rs1_fwd,
    output logic             rs2_fwd,
    output logic [DW-1:0]    fwd_data,
`endif
    output logic             regWrite,
    output logic [AW-1:0]    writeRegister,
    output logic [DW-1:0]    writeData,
    output logic             wb_orphan
);

    localparam int NREG = 1 << AW;

    logic [NREQ-1:0] grant;
    logic            sel_any;
    wb_req_t         sel;
    wb_req_t         wb_q;
    logic            reg_write;
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;
    logic            orphan;
    logic            commit_hit;
    logic            issue_fire;

    rr_arbiter #(.N(NREQ)) u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (req_valid),
        .grant (grant)
    );

    assign req_ready = grant;
    assign sel_any   = |grant;

    always_comb begin
        sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel.rd   = req_rd[i*AW +: AW];
                sel.data = req_data[i*DW +: DW];
            end
        end
    end

    // x0 writes complete the handshake but never reach the register file.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reg_write <= 1'b0;
            wb_q      <= '0;
        end else begin
            reg_write <= sel_any && (sel.rd != REG_ZERO);
            if (sel_any)
                wb_q <= sel;
        end
    end

    assign regWrite      = reg_write;
    assign writeRegister = wb_q.rd;
    assign writeData     = wb_q.data;

    assign commit_hit  = reg_write && (wb_q.rd == issue_rd);
    assign issue_ready = !busy[issue_rd] || commit_hit;
    assign issue_fire  = issue_valid && issue_ready && (issue_rd != REG_ZERO);

    // A new issue outranks the commit clearing the same register.
    always_comb begin
        busy_nxt = busy;
        if (reg_write)
            busy_nxt[wb_q.rd] = 1'b0;
        if (issue_fire)
            busy_nxt[issue_rd] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy   <= '0;
            orphan <= 1'b0;
        end else begin
            busy <= busy_nxt;
            if (reg_write && !busy[wb_q.rd])
                orphan <= 1'b1;
        end
    end

    assign wb_orphan = orphan;

`ifdef WB_FORWARD_EN
    assign rs1_fwd  = reg_write && (wb_q.rd == rs1) && (rs1 != REG_ZERO);
    assign rs2_fwd  = reg_write && (wb_q.rd == rs2) && (rs2 != REG_ZERO);
    assign fwd_data = wb_q.data;
    assign rs1_busy = busy[rs1] && (rs1 != REG_ZERO) && !rs1_fwd;
    assign rs2_busy = busy[rs2] && (rs2 != REG_ZERO) && !rs2_fwd;
`else
    assign rs1_busy = busy[rs1] && (rs1 != REG_ZERO);
    assign rs2_busy = busy[rs2] && (rs2 != REG_ZERO);
`endif

endmodule
